dmem_fill_responder: RTL

//  Memory-side responder for the processor's data-cache miss path. It accepts the single-cycle dbus_en

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/line_assembler.sv | 46 ++++
 rtl/dmem_fill_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared state encoding and line/beat geometry helpers for the data-cache fill responder.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROBE = 3'd1,
        ST_CHECK = 3'd2,
        ST_WB    = 3'd3,
        ST_RD    = 3'd4,
        ST_FILL  = 3'd5
    } state_e;

    localparam int unsigned DEF_LOG2_LINE_BITS = 7;
    localparam int unsigned DEF_LOG2_BEAT_BITS = 5;

    // Memory beats per cache line; a line never narrower than one beat
    function automatic int unsigned beats_of(input int unsigned log2_line, input int unsigned log2_beat);
        return (log2_line > log2_beat) ? (32'd1 << (log2_line - log2_beat)) : 32'd1;
    endfunction

    function automatic int unsigned line_bytes_of(input int unsigned log2_line);
        return 32'd1 << (log2_line - 3);
    endfunction

    // Beat counters must be able to hold the value BEATS itself
    function automatic int unsigned cnt_width_of(input int unsigned beats);
        return $clog2(beats) + 1;
    endfunction

    localparam int unsigned BEATS     = beats_of(DEF_LOG2_LINE_BITS, DEF_LOG2_BEAT_BITS);
    localparam int unsigned LINEBYTES = line_bytes_of(DEF_LOG2_LINE_BITS);

endpackage

// File: rtl/line_assembler.sv
// Collects read beats into a line buffer, lowest slot first, and flags when the line is complete.
module line_assembler
    import dmem_pkg::*;
#(
    parameter int unsigned BEAT_W = 32,
    parameter int unsigned NBEATS = 4,
    parameter int unsigned CNT_W  = cnt_width_of(NBEATS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       en,
    input  logic                       rvalid,
    input  logic [BEAT_W-1:0]          rdata,
    output logic [BEAT_W*NBEATS-1:0]   line,
    output logic                       full,
    output logic                       last_c
);

    logic [CNT_W-1:0] rcv_cnt;
    logic             take;

    // Beats arriving outside the read phase or after the line is complete are dropped
    assign take   = en && rvalid && !full;
    assign last_c = take && (rcv_cnt == CNT_W'(NBEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcv_cnt <= '0;
            full    <= 1'b0;
            line    <= '0;
        end else if (clear) begin
            rcv_cnt <= '0;
            full    <= 1'b0;
        end else if (take) begin
            for (int unsigned i = 0; i < NBEATS; i++) begin
                if (rcv_cnt == CNT_W'(i)) begin
                    line[i*BEAT_W +: BEAT_W] <= rdata;
                end
            end
            rcv_cnt <= rcv_cnt + CNT_W'(1);
            full    <= last_c;
        end
    end

endmodule

// File: rtl/dmem_fill_responder.sv
// Data-cache miss responder: probes the victim, writes back dirty beats, reads the new line
// from backing memory and writes it into the cache with a single fill strobe.
module dmem_fill_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LOG2DCACHEWIDTHBITS = 7,
    parameter int unsigned LOG2DRAMWIDTHBITS   = 5,
    parameter int unsigned LOG2DCACHEDEPTH     = 9
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                dbus_en,
    input  logic [31:0]                         dbus_address,
    input  logic                                dbus_wren,
    output logic                                dbus_wait,
    output logic [31:0]                         dmem_filladdr,
    output logic [(2**LOG2DCACHEWIDTHBITS)-1:0] dmem_filldata,
    output logic                                dmem_fillwe,
    output logic                                dmem_fillrddirty,
    input  logic [31:0]                         dmem_wbaddr,
    input  logic [(2**LOG2DRAMWIDTHBITS)-1:0]   dmem_wbdata,
    input  logic                                dmem_wbwe,
    output logic                                dmem_wback,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [31:0]                         mem_addr,
    output logic [(2**LOG2DRAMWIDTHBITS)-1:0]   mem_wdata,
    input  logic                                mem_ready,
    input  logic [(2**LOG2DRAMWIDTHBITS)-1:0]   mem_rdata,
    input  logic                                mem_rvalid
);

    localparam int unsigned BEAT_W     = 2**LOG2DRAMWIDTHBITS;
    localparam int unsigned NBEATS     = beats_of(LOG2DCACHEWIDTHBITS, LOG2DRAMWIDTHBITS);
    localparam int unsigned LBYTES     = line_bytes_of(LOG2DCACHEWIDTHBITS);
    localparam int unsigned CNT_W      = cnt_width_of(NBEATS);
    localparam int unsigned BEAT_SHIFT = LOG2DRAMWIDTHBITS - 3;

    state_e             state, state_nxt;
    logic [31:0]        line_addr, line_nxt;
    logic [CNT_W-1:0]   wb_cnt, wb_cnt_nxt;
    logic [CNT_W-1:0]   iss_cnt, iss_cnt_nxt;
    logic               dbus_wait_nxt, fillwe_nxt, fillrddirty_nxt, wback_nxt;
    logic [31:0]        filladdr_nxt;
    logic               mem_req_nxt, mem_we_nxt;
    logic [31:0]        mem_addr_nxt;
    logic [BEAT_W-1:0]  mem_wdata_nxt;
    logic               asm_clear, asm_full, asm_last_c;

    // Store misses allocate exactly like loads; cache depth only sizes the victim address space
    logic unused_ok;
    assign unused_ok = ^{dbus_wren, 32'(LOG2DCACHEDEPTH)};

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [CNT_W-1:0] idx);
        return base + (32'(idx) << BEAT_SHIFT);
    endfunction

    line_assembler #(
        .BEAT_W (BEAT_W),
        .NBEATS (NBEATS),
        .CNT_W  (CNT_W)
    ) u_asm (
        .clk    (clk),
        .reset  (reset),
        .clear  (asm_clear),
        .en     (state == ST_RD),
        .rvalid (mem_rvalid),
        .rdata  (mem_rdata),
        .line   (dmem_filldata),
        .full   (asm_full),
        .last_c (asm_last_c)
    );

    // Next state, counters and next values of every registered output
    always_comb begin
        state_nxt       = state;
        line_nxt        = line_addr;
        wb_cnt_nxt      = wb_cnt;
        iss_cnt_nxt     = iss_cnt;
        mem_req_nxt     = mem_req;
        mem_we_nxt      = mem_we;
        mem_addr_nxt    = mem_addr;
        mem_wdata_nxt   = mem_wdata;
        wback_nxt       = 1'b0;
        asm_clear       = 1'b0;
        dbus_wait_nxt   = 1'b0;
        fillrddirty_nxt = 1'b0;
        fillwe_nxt      = 1'b0;
        filladdr_nxt    = '0;

        case (state)
            ST_IDLE: begin
                if (dbus_en && !dbus_address[31]) begin
                    state_nxt   = ST_PROBE;
                    line_nxt    = dbus_address & ~32'(LBYTES - 1);
                    wb_cnt_nxt  = '0;
                    iss_cnt_nxt = '0;
                    asm_clear   = 1'b1;
                end
            end
            ST_PROBE: begin
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                mem_req_nxt = 1'b1;
                if (dmem_wbwe) begin
                    state_nxt     = ST_WB;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = dmem_wbaddr;
                    mem_wdata_nxt = dmem_wbdata;
                end else begin
                    state_nxt     = ST_RD;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = line_addr;
                    mem_wdata_nxt = '0;
                    iss_cnt_nxt   = '0;
                end
            end
            ST_WB: begin
                if (mem_ready) begin
                    wback_nxt     = 1'b1;
                    wb_cnt_nxt    = wb_cnt + CNT_W'(1);
                    mem_we_nxt    = 1'b0;
                    mem_wdata_nxt = '0;
                    if (wb_cnt == CNT_W'(NBEATS - 1)) begin
                        state_nxt    = ST_RD;
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = line_addr;
                        iss_cnt_nxt  = '0;
                    end else begin
                        state_nxt    = ST_PROBE;
                        mem_req_nxt  = 1'b0;
                        mem_addr_nxt = '0;
                    end
                end
            end
            ST_RD: begin
                // Issue and receive run independently; rvalid may overlap a later ready
                if (mem_req && mem_ready) begin
                    iss_cnt_nxt = iss_cnt + CNT_W'(1);
                    if (iss_cnt_nxt == CNT_W'(NBEATS)) begin
                        mem_req_nxt  = 1'b0;
                        mem_addr_nxt = '0;
                    end else begin
                        mem_addr_nxt = beat_addr(line_addr, iss_cnt_nxt);
                    end
                end
                if (asm_last_c || asm_full) begin
                    state_nxt    = ST_FILL;
                    mem_req_nxt  = 1'b0;
                    mem_addr_nxt = '0;
                end
            end
            ST_FILL: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        dbus_wait_nxt   = (state_nxt != ST_IDLE);
        fillrddirty_nxt = (state_nxt == ST_PROBE);
        fillwe_nxt      = (state_nxt == ST_FILL);
        if (state_nxt == ST_PROBE) begin
            filladdr_nxt = beat_addr(line_nxt, wb_cnt_nxt);
        end else if (state_nxt == ST_FILL) begin
            filladdr_nxt = line_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            line_addr        <= '0;
            wb_cnt           <= '0;
            iss_cnt          <= '0;
            dbus_wait        <= 1'b0;
            dmem_filladdr    <= '0;
            dmem_fillwe      <= 1'b0;
            dmem_fillrddirty <= 1'b0;
            dmem_wback       <= 1'b0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
        end else begin
            state            <= state_nxt;
            line_addr        <= line_nxt;
            wb_cnt           <= wb_cnt_nxt;
            iss_cnt          <= iss_cnt_nxt;
            dbus_wait        <= dbus_wait_nxt;
            dmem_filladdr    <= filladdr_nxt;
            dmem_fillwe      <= fillwe_nxt;
            dmem_fillrddirty <= fillrddirty_nxt;
            dmem_wback       <= wback_nxt;
            mem_req          <= mem_req_nxt;
            mem_we           <= mem_we_nxt;
            mem_addr         <= mem_addr_nxt;
            mem_wdata        <= mem_wdata_nxt;
        end
    end

endmodule
